// File: rtl/rd_fifo_bus_arbiter_pkg.sv
//==============================================================================
// Module  : rd_fifo_bus_arbiter_pkg
// Brief   : Shared FSM encoding and round-robin helper for the read-FIFO arbiter.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

package rd_fifo_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } arb_state_e;

  // Successor of cur in a ring of n slots.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return ((cur + 1) >= n) ? 0 : (cur + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rd_fifo_bus_arbiter_picker.sv
//==============================================================================
// Module  : rd_fifo_rr_picker
// Brief   : Combinational round-robin picker: first requester at or after ptr.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module rd_fifo_rr_picker
  import rd_fifo_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic [NUM_CH-1:0]         req_i,
  input  logic [$clog2(NUM_CH)-1:0] ptr_i,
  output logic                      found_o,
  output logic [$clog2(NUM_CH)-1:0] idx_o
);

  localparam int IDX_W = $clog2(NUM_CH);

  // Walk from farthest to nearest so the closest requester to ptr wins.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (req_i[(int'(ptr_i) + k) % NUM_CH]) begin
        found_o = 1'b1;
        idx_o   = IDX_W'((int'(ptr_i) + k) % NUM_CH);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rd_fifo_bus_arbiter.sv
//==============================================================================
// Module  : rd_fifo_bus_arbiter
// Brief   : Round-robin page arbiter sharing one read-FIFO consumer among
//           NUM_CH channel FIFOs; reports per-page worst error code.
//           Optional stall timeout: define RD_FIFO_ARB_TIMEOUT_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module rd_fifo_bus_arbiter
  import rd_fifo_bus_arbiter_pkg::*;
#(
  parameter int NUM_CH             = 4,
  parameter int RD_FIFO_DATA_WIDTH = 136,
  parameter int ERROR_CODE_WIDTH   = 8,
  parameter int WORDS_PER_PAGE     = 256,
  parameter int TIMEOUT_CYCLES     = 4096
) (
  input  logic                               i_clk,
  input  logic                               i_rst_n,
  input  logic [NUM_CH-1:0]                  i_req,
  output logic [NUM_CH-1:0]                  o_grant,
  input  logic [NUM_CH*RD_FIFO_DATA_WIDTH-1:0] i_rd_fifo_data,
  input  logic [NUM_CH-1:0]                  i_rd_fifo_empty,
  output logic [NUM_CH-1:0]                  o_rd_fifo_re,
  output logic [RD_FIFO_DATA_WIDTH-1:0]      o_data,
  output logic                               o_empty,
  input  logic                               i_re,
  output logic                               o_busy,
  output logic                               o_done,
  output logic [$clog2(NUM_CH)-1:0]          o_done_ch,
  output logic [ERROR_CODE_WIDTH-1:0]        o_done_err
);

  localparam int CH_W   = $clog2(NUM_CH);
  localparam int BEAT_W = $clog2(WORDS_PER_PAGE) + 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(WORDS_PER_PAGE - 1);

  arb_state_e                  state_q;
  logic [CH_W-1:0]             sel_q;
  logic [CH_W-1:0]             rr_ptr_q;
  logic [CH_W-1:0]             done_ch_q;
  logic [NUM_CH-1:0]           grant_q;
  logic [BEAT_W-1:0]           beat_q;
  logic [ERROR_CODE_WIDTH-1:0] err_q;
  logic [ERROR_CODE_WIDTH-1:0] done_err_q;
  logic                        done_q;

  logic                          pick_found;
  logic [CH_W-1:0]               pick_idx;
  logic [RD_FIFO_DATA_WIDTH-1:0] head;
  logic [ERROR_CODE_WIDTH-1:0]   head_err;
  logic [ERROR_CODE_WIDTH-1:0]   err_d;
  logic                          in_xfer;
  logic                          pop;

`ifdef RD_FIFO_ARB_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [STALL_W-1:0] stall_q;
`endif

  rd_fifo_rr_picker #(
    .NUM_CH (NUM_CH)
  ) u_picker (
    .req_i   (i_req),
    .ptr_i   (rr_ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  assign head     = i_rd_fifo_data[sel_q*RD_FIFO_DATA_WIDTH +: RD_FIFO_DATA_WIDTH];
  assign head_err = head[RD_FIFO_DATA_WIDTH-1 -: ERROR_CODE_WIDTH];
  assign err_d    = (head_err > err_q) ? head_err : err_q;
  assign in_xfer  = (state_q == ST_XFER);

  // Outside XFER the port looks empty, so the word after a page is never exposed.
  assign o_empty      = in_xfer ? i_rd_fifo_empty[sel_q] : 1'b1;
  assign pop          = in_xfer & i_re & ~o_empty;
  assign o_rd_fifo_re = pop ? grant_q : '0;
  assign o_data       = head;
  assign o_grant      = grant_q;
  assign o_busy       = (state_q == ST_XFER) || (state_q == ST_DONE);
  assign o_done       = done_q;
  assign o_done_ch    = done_ch_q;
  assign o_done_err   = done_err_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_IDLE;
      sel_q      <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_q     <= '0;
      err_q      <= '0;
      done_q     <= 1'b0;
      done_ch_q  <= '0;
      done_err_q <= '0;
`ifdef RD_FIFO_ARB_TIMEOUT_EN
      stall_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef RD_FIFO_ARB_TIMEOUT_EN
      stall_q <= '0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (pick_found) begin
            sel_q   <= pick_idx;
            grant_q <= NUM_CH'(1) << pick_idx;
            beat_q  <= '0;
            err_q   <= '0;
            state_q <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (pop) begin
            beat_q <= beat_q + 1'b1;
            err_q  <= err_d;
            if (beat_q == LAST_BEAT) begin
              state_q    <= ST_DONE;
              done_q     <= 1'b1;
              done_ch_q  <= sel_q;
              done_err_q <= err_d;
            end
          end
`ifdef RD_FIFO_ARB_TIMEOUT_EN
          else if (stall_q == STALL_W'(TIMEOUT_CYCLES - 1)) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            done_ch_q  <= sel_q;
            done_err_q <= '1;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
`endif
        end
        ST_DONE: begin
          grant_q  <= '0;
          rr_ptr_q <= CH_W'(rr_next(int'(sel_q), NUM_CH));
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rd_fifo_bus_arbiter.sv
//==============================================================================
// Module  : tb_rd_fifo_bus_arbiter
// Brief   : Scoreboard bench for rd_fifo_bus_arbiter (4 channels, 4-word pages).
// Revision: 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rd_fifo_bus_arbiter;

  localparam int NCH = 4;
  localparam int W   = 136;
  localparam int EW  = 8;
  localparam int WPP = 4;
  localparam int TO  = 8;
  localparam int CHW = 2;

  logic                 i_clk = 1'b0;
  logic                 i_rst_n = 1'b0;
  logic [NCH-1:0]       i_req = '0;
  logic [NCH-1:0]       o_grant;
  logic [NCH*W-1:0]     i_rd_fifo_data;
  logic [NCH-1:0]       i_rd_fifo_empty;
  logic [NCH-1:0]       o_rd_fifo_re;
  logic [W-1:0]         o_data;
  logic                 o_empty;
  logic                 i_re = 1'b0;
  logic                 o_busy;
  logic                 o_done;
  logic [CHW-1:0]       o_done_ch;
  logic [EW-1:0]        o_done_err;

  always #5 i_clk = ~i_clk;

  rd_fifo_bus_arbiter #(
    .NUM_CH             (NCH),
    .RD_FIFO_DATA_WIDTH (W),
    .ERROR_CODE_WIDTH   (EW),
    .WORDS_PER_PAGE     (WPP),
    .TIMEOUT_CYCLES     (TO)
  ) dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_req           (i_req),
    .o_grant         (o_grant),
    .i_rd_fifo_data  (i_rd_fifo_data),
    .i_rd_fifo_empty (i_rd_fifo_empty),
    .o_rd_fifo_re    (o_rd_fifo_re),
    .o_data          (o_data),
    .o_empty         (o_empty),
    .i_re            (i_re),
    .o_busy          (o_busy),
    .o_done          (o_done),
    .o_done_ch       (o_done_ch),
    .o_done_err      (o_done_err)
  );

  // Channel FIFO model: endless streams, word = {err, channel, index}.
  logic [7:0]     err_mem [NCH][128];
  int             rdptr  [NCH] = '{default: 0};
  int             popcnt [NCH] = '{default: 0};
  logic [NCH-1:0] force_empty = '0;
  int             ncmp = 0;
  int             nerr = 0;
  int             donecnt = 0;
  int             cyc = 0;

  typedef struct {
    int ch;
    int err;
  } exp_t;
  exp_t sb[$];
  int   done_cyc[$];

  assign i_rd_fifo_empty = force_empty;

  always_comb begin
    i_rd_fifo_data = '0;
    for (int c = 0; c < NCH; c++)
      i_rd_fifo_data[c*W +: W] = {err_mem[c][rdptr[c] % 128], 64'(c), 64'(rdptr[c])};
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    for (int c = 0; c < NCH; c++) begin
      if (o_rd_fifo_re[c]) begin
        rdptr[c]  <= rdptr[c] + 1;
        popcnt[c] <= popcnt[c] + 1;
      end
    end
  end

  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n) begin
      check_val("re_within_grant", 64'(o_rd_fifo_re & ~o_grant), 64'd0);
      for (int c = 0; c < NCH; c++) begin
        if (o_rd_fifo_re[c]) begin
          check_val("pop_word_ch", o_data[127:64], 64'(c));
          check_val("pop_word_idx", o_data[63:0], 64'(rdptr[c]));
        end
      end
      if (o_done) begin
        donecnt++;
        done_cyc.push_back(cyc);
        if (sb.size() == 0) begin
          check_val("done_unexpected", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          check_val("done_ch", 64'(o_done_ch), 64'(e.ch));
          check_val("done_err", 64'(o_done_err), 64'(e.err));
        end
      end
    end
  end

  task automatic wait_done(input int target, input int budget);
    for (int i = 0; i < budget && donecnt < target; i++) begin
      @(negedge i_clk);
      #1;
    end
    check_val("wait_done_in_budget", 64'(donecnt >= target), 64'd1);
  endtask

  task automatic wait_pops(input int ch, input int target, input int budget);
    for (int i = 0; i < budget && popcnt[ch] < target; i++) @(negedge i_clk);
    check_val("wait_pops_in_budget", 64'(popcnt[ch] >= target), 64'd1);
  endtask

  task automatic request(input logic [NCH-1:0] mask);
    i_req = mask;
    repeat (2) @(negedge i_clk);
    i_req = '0;
  endtask

  initial begin
    int base;
    int dbase;
    int c0;
    int n;
    for (int c = 0; c < NCH; c++)
      for (int k = 0; k < 128; k++) err_mem[c][k] = 8'h00;

    // Reset values
    repeat (3) @(negedge i_clk);
    check_val("rst_grant", 64'(o_grant), 64'd0);
    check_val("rst_re", 64'(o_rd_fifo_re), 64'd0);
    check_val("rst_empty", 64'(o_empty), 64'd1);
    check_val("rst_busy", 64'(o_busy), 64'd0);
    check_val("rst_done", 64'(o_done), 64'd0);
    check_val("rst_done_ch", 64'(o_done_ch), 64'd0);
    check_val("rst_done_err", 64'(o_done_err), 64'd0);
    i_rst_n = 1'b1;

    // 1: single request on ch2
    sb.push_back('{2, 0});
    i_req = 4'b0100;
    i_re  = 1'b1;
    @(negedge i_clk);
    check_val("t1_grant", 64'(o_grant), 64'b0100);
    check_val("t1_busy", 64'(o_busy), 64'd1);
    i_req = '0;
    wait_done(1, 20);
    check_val("t1_empty_in_done", 64'(o_empty), 64'd1);
    check_val("t1_pops_ch2", 64'(popcnt[2]), 64'd4);
    check_val("t1_pops_other", 64'(popcnt[0] + popcnt[1] + popcnt[3]), 64'd0);

    // 2: all channels requesting from a fresh pointer
    @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) sb.push_back('{k % NCH, 0});
    dbase = donecnt;
    i_req = 4'b1111;
    wait_done(dbase + 5, 60);
    i_req = '0;
    n = done_cyc.size();
    for (int k = n - 4; k < n; k++)
      check_val("t2_page_period", 64'(done_cyc[k] - done_cyc[k-1]), 64'd6);
    repeat (10) @(negedge i_clk);
    check_val("t2_no_extra_page", 64'(donecnt), 64'(dbase + 5));
    check_val("t2_idle_busy", 64'(o_busy), 64'd0);

    // 3: worst error code on ch1, then accumulator cleared
    for (int k = 0; k < 4; k++) err_mem[1][rdptr[1] + k] = (k == 0) ? 8'd3 : (k == 1) ? 8'd0 : (k == 2) ? 8'd7 : 8'd5;
    sb.push_back('{1, 7});
    dbase = donecnt;
    request(4'b0010);
    wait_done(dbase + 1, 20);
    sb.push_back('{1, 0});
    request(4'b0010);
    wait_done(dbase + 2, 20);

    // 4: ch0 runs dry mid-page
    base = popcnt[0];
    dbase = donecnt;
    sb.push_back('{0, 0});
    i_req = 4'b0001;
    wait_pops(0, base + 2, 20);
    force_empty[0] = 1'b1;
    i_req = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge i_clk);
      #1;
      check_val("t4_no_pop_in_gap", 64'(o_rd_fifo_re), 64'd0);
    end
    check_val("t4_busy_in_gap", 64'(o_busy), 64'd1);
    force_empty[0] = 1'b0;
    wait_done(dbase + 1, 20);
    repeat (4) @(negedge i_clk);
    check_val("t4_total_pops", 64'(popcnt[0] - base), 64'd4);
    check_val("t4_done_once", 64'(donecnt), 64'(dbase + 1));

    // 5: reset mid-transfer
    base = popcnt[0];
    dbase = donecnt;
    i_req = 4'b0001;
    wait_pops(0, base + 2, 20);
    i_req = '0;
    i_rst_n = 1'b0;
    #1;
    check_val("t5_grant_in_rst", 64'(o_grant), 64'd0);
    check_val("t5_busy_in_rst", 64'(o_busy), 64'd0);
    check_val("t5_re_in_rst", 64'(o_rd_fifo_re), 64'd0);
    repeat (3) @(negedge i_clk);
    check_val("t5_no_done", 64'(donecnt), 64'(dbase));
    check_val("t5_pops_kept", 64'(popcnt[0] - base), 64'd2);
    i_rst_n = 1'b1;
    sb.push_back('{0, 0});
    i_req = 4'b0001;
    @(negedge i_clk);
    check_val("t5_restart_grant", 64'(o_grant), 64'b0001);
    i_req = '0;
    wait_done(dbase + 1, 20);

    // 6: stall after one pop
    repeat (2) @(negedge i_clk);
    base = popcnt[0];
    dbase = donecnt;
`ifdef RD_FIFO_ARB_TIMEOUT_EN
    sb.push_back('{0, 255});
`endif
    i_req = 4'b0001;
    wait_pops(0, base + 1, 20);
    force_empty[0] = 1'b1;
    i_req = '0;
    c0 = cyc;
`ifdef RD_FIFO_ARB_TIMEOUT_EN
    wait_done(dbase + 1, 20);
    check_val("t6_stall_cycles", 64'(done_cyc[done_cyc.size()-1] - c0), 64'(TO));
    check_val("t6_pops", 64'(popcnt[0] - base), 64'd1);
    force_empty[0] = 1'b0;
`else
    repeat (100) @(negedge i_clk);
    check_val("t6_no_done_stalled", 64'(donecnt), 64'(dbase));
    check_val("t6_still_busy", 64'(o_busy), 64'd1);
    sb.push_back('{0, 0});
    force_empty[0] = 1'b0;
    wait_done(dbase + 1, 20);
    check_val("t6_pops", 64'(popcnt[0] - base), 64'd4);
`endif

    repeat (3) @(negedge i_clk);
    check_val("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
